// File: rtl/nios2_oci_trace_pkg.sv
// Shared constants, FSM states and output word layout for the OCI trace DCT packer.
package nios2_oci_trace_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned SLOTS  = 15;
  localparam int unsigned BUF_W  = CODE_W * SLOTS;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    LAST,
    DONE
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] dct_count;
    logic [BUF_W-1:0] dct_buffer;
  } dct_word_t;

endpackage

// File: rtl/nios2_oci_dct_accum.sv
// Right-aligned code shift register with slot counter; clear and shift may combine
// so that a code arriving with a word hand-off lands in slot 1 of the fresh word.
module nios2_oci_dct_accum
  import nios2_oci_trace_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_i,
  input  logic              clear_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [BUF_W-1:0]  acc_o,
  output logic [BUF_W-1:0]  shifted_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [BUF_W-1:0] acc_q, acc_d, base_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_acc = clear_i ? '0 : acc_q;
    base_cnt = clear_i ? '0 : cnt_q;
    acc_d    = base_acc;
    cnt_d    = base_cnt;
    if (shift_i) begin
      acc_d = {base_acc[BUF_W-CODE_W-1:0], code_i};
      cnt_d = base_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o     = acc_q;
  assign cnt_o     = cnt_q;
  assign shifted_o = {acc_q[BUF_W-CODE_W-1:0], code_i};

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 15-slot words, double-buffered behind a valid/ready
// output, and sequences the end-of-test flush and test_ending/test_has_ended pair.
module nios2_oci_dct_packer
  import nios2_oci_trace_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  input  logic              end_req,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  state_e           state_q, state_d;
  logic             en_q;
  logic             valid_q;
  dct_word_t        out_q, load_word;
  logic             ending_q, ending_d;
  logic             ended_q;

  logic             shift, clear, load;
  logic             out_free, xfer;
  logic [BUF_W-1:0] acc, shifted;
  logic [CNT_W-1:0] cnt;

  nios2_oci_dct_accum u_accum (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .shift_i   (shift),
    .clear_i   (clear),
    .code_i    (code),
    .acc_o     (acc),
    .shifted_o (shifted),
    .cnt_o     (cnt)
  );

  assign out_free   = !valid_q | dct_ready;
  // en_q holds code_ready low for the first cycle after reset release.
  assign code_ready = en_q & (state_q == ACCUM) & ((cnt < CNT_W'(SLOTS)) | out_free);
  assign xfer       = code_valid & code_ready;

  always_comb begin
    state_d   = state_q;
    shift     = 1'b0;
    clear     = 1'b0;
    load      = 1'b0;
    load_word = '0;
    ending_d  = 1'b0;
    case (state_q)
      ACCUM: begin
        if (cnt == CNT_W'(SLOTS)) begin
          if (out_free) begin
            load      = 1'b1;
            load_word = '{dct_count: CNT_W'(SLOTS), dct_buffer: acc};
            clear     = 1'b1;
            shift     = xfer;
          end
        end else if (xfer) begin
          // The 15th code goes straight to the output register when it is free.
          if (cnt == CNT_W'(SLOTS - 1) && out_free) begin
            load      = 1'b1;
            load_word = '{dct_count: CNT_W'(SLOTS), dct_buffer: shifted};
            clear     = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
        if (end_req) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt != '0) begin
          if (out_free) begin
            load      = 1'b1;
            load_word = '{dct_count: cnt, dct_buffer: acc};
            clear     = 1'b1;
            state_d   = LAST;
          end
        end else if (out_free) begin
          state_d  = DONE;
          ending_d = 1'b1;
        end
      end
      LAST: begin
        if (valid_q && dct_ready) begin
          state_d  = DONE;
          ending_d = 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ACCUM;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= (state_d == ACCUM);
      ending_q <= ending_d;
      ended_q  <= ended_q | ending_d;
      if (load) begin
        valid_q <= 1'b1;
        out_q   <= load_word;
      end else if (dct_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dct_valid      = valid_q;
  assign dct_buffer     = out_q.dct_buffer;
  assign dct_count      = out_q.dct_count;
  assign test_ending    = ending_q;
  assign test_has_ended = ended_q;

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
- Upstream stage of the OCI trace test-bench monitor.
- Packs 2-bit data-capture trace (DCT) codes into a 30-bit dct_buffer plus a 4-bit dct_count.
- Hands each full or flushed word downstream over a valid/ready handshake.
- Generates the end-of-test pair test_ending / test_has_ended consumed by the monitor.

Parameters:
- CODE_W, 2, width of one trace code.
- SLOTS, 15, codes per packed word.
- BUF_W, 30, packed buffer width; must equal CODE_W*SLOTS.
- CNT_W, 4, slot counter width; must satisfy 2**CNT_W > SLOTS.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- code_valid  in  1  trace code offered.
- code  in  CODE_W  trace code value.
- code_ready  out  1  packer accepts code this cycle.
- end_req  in  1  single-cycle request: flush partial word and end test.
- dct_valid  out  1  output word valid.
- dct_ready  in  1  downstream accepts the word.
- dct_buffer  out  BUF_W  packed codes; oldest code in the highest occupied slot.
- dct_count  out  CNT_W  number of valid codes in dct_buffer, 1..SLOTS.
- test_ending  out  1  one-cycle pulse when the final word is accepted.
- test_has_ended  out  1  sticky flag, set with test_ending.

Behaviour:
- Reset (async, reset_n=0): all outputs 0.
  - code_ready, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended = 0.
  - Internal accumulator and slot count cleared; state = ACCUM.
  - code_ready rises 1 cycle after reset_n deasserts.
- Reset mid-operation discards the partial accumulator and any pending output word. No flush occurs.
- Accumulator path, on a code transfer (code_valid & code_ready):
  - acc <= {acc[BUF_W-CODE_W-1:0], code}; cnt <= cnt+1.
  - Codes are right-aligned: a partial word of n codes occupies bits [CODE_W*n-1:0]. Upper bits are 0.
- Output register is separate from the accumulator (double buffer).
  - "out_free" = !dct_valid | dct_ready.
- Full transfer:
  - Condition: cnt==SLOTS and out_free.
  - Action: dct_buffer<=acc, dct_count<=SLOTS, dct_valid<=1, acc/cnt cleared.
  - If a code arrives the same cycle, it is written as slot 1 of the fresh accumulator (cnt=1). Codes are never lost.
- code_ready:
  - In ACCUM: (cnt<SLOTS) | out_free.
  - In FLUSH and DONE: 0.
- dct_valid, once set, holds with stable dct_buffer/dct_count until dct_ready. Cleared the cycle after acceptance unless reloaded.
- Latency: the 15th code is accepted in cycle t; the word is visible at t+1 if out_free at t. The transfer check uses cnt after the increment.
- State machine:
  - ACCUM: normal packing. end_req -> FLUSH. end_req is ignored in other states. A code accepted in the same cycle as end_req is included in the flush.
  - FLUSH: no codes accepted.
    - If cnt>0 and out_free: load partial word (dct_count=cnt), clear acc, go to LAST.
    - If cnt==0: wait until out_free (the pending word is accepted or there is none), then go to DONE. test_ending pulses on that transition.
  - LAST: wait for dct_valid & dct_ready, then -> DONE; test_ending=1 for exactly that cycle (registered, visible next cycle).
  - DONE: test_has_ended=1 (sticky until reset); code_ready=0; dct_valid=0. Only reset exits.
- Boundary cases:
  - cnt==SLOTS with output blocked: code_ready=0 and acc holds.
  - end_req with an empty accumulator and no pending word: test_ending pulses on the 2nd cycle after end_req; no word is emitted.
  - dct_count is never 0 while dct_valid=1.

Decomposition:
- Shared package nios2_oci_trace_pkg:
  - Constants CODE_W, SLOTS, BUF_W, CNT_W.
  - State enum {ACCUM, FLUSH, LAST, DONE}.
  - Output word struct {dct_count, dct_buffer}.
- One natural sub-module, nios2_oci_dct_accum: shift register plus slot counter with load/clear. The FSM and output register stay in the top.

Test Plan:
- Full pack: 15 back-to-back codes 3,2,1,0,3,... with dct_ready=1 -> one word, dct_count=15, dct_buffer=30'h39393939 pattern (first code in bits[29:28]), valid 1 cycle after the 15th code.
- Backpressure: dct_ready=0, 31 codes offered -> first word held stable; code_ready drops after the 30th accepted code; on dct_ready=1 two words drain in order; no code lost.
- Simultaneous: 16th code arrives in the same cycle the full word transfers -> next word's cnt starts at 1 and its final dct_buffer[1:0] region holds that code correctly.
- Partial flush: 5 codes of 1 then end_req -> dct_count=5, dct_buffer=30'h155; after acceptance test_ending pulses 1 cycle and test_has_ended stays 1; code_ready=0 thereafter.
- Empty end: end_req with no codes -> no dct_valid; test_ending pulses at t+2; test_has_ended=1.
- Mid-op reset: reset_n low after 7 codes with a word pending -> all outputs 0 asynchronously; after release, 15 new codes produce a clean word with dct_count=15.
